// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor; reused for every bit position by the serial datapath.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin: one bit per cycle, LSB first, with a valid/ready
// handshake on both the operand and the result side.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       r_state;
  sub_state_e       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_shiftNext;
  logic             w_last;

  full_subtractor u_fs (
    .a    (r_a[r_cnt]),
    .b    (r_b[r_cnt]),
    .bin  (r_br),
    .diff (w_d),
    .bout (w_bout)
  );

  assign w_shiftNext = {w_d, r_shift[WIDTH-1:1]};
  assign w_last      = (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Results are published only on the last RUN edge, so the visible outputs
  // hold their previous values while the next operation is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_shift <= w_shiftNext;
          r_br    <= w_bout;
          if (w_last) begin
            r_diff <= w_shiftNext;
            r_bout <= w_bout;
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d != r_a[WIDTH-1]);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH = 4.
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] diff;
  logic       bout;
  logic       ovf;

  int testsRun;
  int testsFailed;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one operand set, scrambles the inputs after capture, and checks
  // latency plus the result once out_valid rises (no handshake).
  task automatic applyStimulus(input string tag, input logic [3:0] a,
                               input logic [3:0] b, input logic bi,
                               input logic [3:0] expDiff, input logic expBout,
                               input logic expOvf);
    int lat;
    @(negedge clk);
    A = a; B = b; bin = bi; in_valid = 1'b1;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; A = ~a; B = ~b; bin = ~bi;
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
    checkOutput({tag, "_diff"}, 32'(diff), 32'(expDiff));
    checkOutput({tag, "_bout"}, 32'(bout), 32'(expBout));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
    checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 4'd0; B = 4'd0; bin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_diff", 32'(diff), 32'd0);
    checkOutput("rst_bout", 32'(bout), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b1;

    applyStimulus("5m3", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    handshake("5m3");
    applyStimulus("3m5", 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0);
    handshake("3m5");
    applyStimulus("8m1", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
    handshake("8m1");
    applyStimulus("7m15", 4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1);
    handshake("7m15");
    applyStimulus("0m0b", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);

    // Back-pressure: result must hold while new operands are offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = 4'b1010; B = 4'b0110; bin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_diff", 32'(diff), 32'hF);
      checkOutput("hold_bout", 32'(bout), 32'd1);
    end
    handshake("hold");
    checkOutput("keep_diff", 32'(diff), 32'hF);
    applyStimulus("6m1", 4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0);
    handshake("6m1");

    // Abort during the second RUN cycle.
    @(negedge clk);
    A = 4'b0110; B = 4'b0010; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus("9m4", 4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b1);
    handshake("9m4");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, minimum 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set A/B/bin presented.
REQ-005 in_ready  output  1  block accepts an operand set this cycle.
REQ-006 A  input  WIDTH  minuend.
REQ-007 B  input  WIDTH  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 diff  output  WIDTH  A - B - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  borrow-out; 1 when unsigned A < B + bin.
REQ-013 ovf  output  1  two's-complement overflow of A - B - bin.

Function
REQ-014 FSM states: IDLE, RUN, DONE; in_ready is 1 only in IDLE, out_valid is 1 only in DONE, both decoded from registered state.
REQ-015 IDLE: on rising edge with in_valid=1, the block captures A, B, and bin (into the borrow register), clears the bit counter, and moves to RUN.
REQ-016 RUN: each cycle, one bit is processed LSB first: d = a XOR b XOR br; br_next = (~a & b) | (~a & br) | (b & br); d is shifted into the diff register.
REQ-017 The transition RUN -> DONE occurs on the edge that processes bit WIDTH-1; out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-018 On entry to DONE, bout = final borrow register; ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]), using the captured operands.
REQ-019 DONE: diff, bout, and ovf stay stable until a rising edge with out_valid=1 and out_ready=1; that edge moves the FSM to IDLE.
REQ-020 No overlap: a new operand set is accepted no earlier than the edge after the output handshake; minimum issue interval is WIDTH+2 cycles.
REQ-021 in_valid is ignored in RUN and DONE; changes on A/B/bin after capture do not affect the result.
REQ-022 After a handshake, diff/bout/ovf keep their last values until the next DONE entry; consumers use them only while out_valid=1.
REQ-023 The bit counter is ceil(log2(WIDTH)) bits wide and never wraps within one operation.
REQ-024 Unused/illegal state encodings return to IDLE on the next edge.

Reset
REQ-025 While reset=0: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, counter=0, borrow register=0.
REQ-026 Reset asserted in RUN or DONE aborts the operation immediately, with no result delivered; the first edge after release may accept a new operand set.

Structure
REQ-027 Shared package sub_pkg holds the state enum typedef (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-028 One sub-module, full_subtractor (a, b, bin, diff, bout; purely combinational), is instantiated once and reused on every RUN cycle.
REQ-029 Total RTL is 120-400 lines; no ripple chain of WIDTH subtractor instances.

Verification
REQ-030 A=0101, B=0011, bin=0 -> diff=0010, bout=0, ovf=0; out_valid exactly 4 cycles after the accepting edge.
REQ-031 A=0011, B=0101, bin=0 -> diff=1110, bout=1, ovf=0.
REQ-032 A=1000, B=0001, bin=0 -> diff=0111, bout=0, ovf=1; and A=0111, B=1111, bin=0 -> diff=1000, bout=1, ovf=1.
REQ-033 A=0000, B=0000, bin=1 -> diff=1111, bout=1, ovf=0.
REQ-034 Hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> outputs stable and in_ready=0; set out_ready=1 -> IDLE next edge; next operation returns the correct new result.
REQ-035 Assert reset during the 2nd RUN cycle -> out_valid=0, diff=0, in_ready=1 immediately; after release, A=1001, B=0100, bin=0 -> diff=0101, bout=0, ovf=1.
